ecc_hamming_74_mem_ctrl: RTL
============================

Name: ecc_hamming_74_mem_ctrl

Overview:
- ECC-protected 4-bit-data memory controller built around the (7,4) Hamming SECDED code (7-bit codeword plus extra overall parity, 8 bits stored per word).
- Encodes user writes, and decodes and corrects user reads.
- Runs a background scrubber that walks every address and writes back single-bit-corrected words.
- Arbitrates the single memory port between the user request port and the scrubber.

Parameters:
- AW, 4, address width; DEPTH = 2**AW words.
- SCRUB_INTERVAL, 256, cycles between scrub requests while scrub_en=1 (minimum 4).
- CNT_W, 16, width of the error counters (saturating).

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous active-high reset.
- req_valid  input  1  user request valid.
- req_ready  output  1  user request accepted when valid&ready.
- req_write  input  1  1=write, 0=read.
- req_addr  input  AW  word address.
- req_wdata  input  4  write data.
- rsp_valid  output  1  one-cycle read response pulse; no backpressure.
- rsp_rdata  output  4  read data (corrected where possible).
- rsp_err_corr  output  1  single-bit error corrected (includes extra-parity-bit error).
- rsp_err_uncorr  output  1  double-bit error detected; data uncorrected.
- scrub_en  input  1  enables the background scrubber.
- inj_valid  input  1  test-only error injection strobe.
- inj_addr  input  AW  injection address.
- inj_mask  input  8  XORed into the stored word {extra_parity, codeword[6:0]}.
- corr_count  output  CNT_W  corrected-error count, user and scrub, saturating.
- uncorr_count  output  CNT_W  uncorrectable-error count, saturating.

Behaviour:
- Reset:
  - state=IDLE, req_ready=0 during rst.
  - rsp_* = 0, counters = 0, scrub timer = 0, scrub_addr = 0, scrub_pending = 0, last_grant = USER.
  - All memory words cleared to 8'h00, which is the valid codeword for data 0.
  - Reset mid-operation aborts any read or writeback; no response is issued.
- Memory: synchronous-read register array; 1 read or 1 write per cycle.
- FSM states IDLE, CHK, WB:
  - IDLE: req_ready=1 unless a scrub is granted this cycle.
    - User write accepted at cycle T: encoded word written at the T clock edge; stays IDLE; no response.
    - User read accepted at T: address registered; next state is CHK.
    - Scrub grant: read scrub_addr; next state is CHK; req_ready=0 that cycle.
  - CHK at T+1: RAM data is decoded combinationally.
    - Syndrome s = recomputed parity bits (s[0]=cw0^cw2^cw4^cw6, s[1]=cw1^cw2^cw5^cw6, s[2]=cw3^cw4^cw5^cw6).
    - Overall parity p = XOR of all 8 stored bits.
    - p=0, s=0: clean.
    - p=1: single error. If s≠0, flip codeword bit s-1. If s=0, the extra-parity bit is in error. Correctable.
    - p=0, s≠0: double error, uncorrectable.
    - Data = {cw6,cw5,cw4,cw2} after any correction.
    - User read: registered response; rsp_valid=1 at T+2 for exactly one cycle.
    - Correctable error: next state is WB. Otherwise next state is IDLE. req_ready=0 in CHK.
  - WB: write the re-encoded corrected word to the same address; next state is IDLE; req_ready=0.
- Latency: read response at T+2. Back-to-back reads are accepted every 2 cycles when clean, every 3 when corrected.
- Counters: corr_count += 1 on a correctable CHK; uncorr_count += 1 on an uncorrectable CHK, user or scrub. Both hold at all-ones.
- Scrubber:
  - Timer increments while scrub_en=1. At SCRUB_INTERVAL-1 it sets scrub_pending and wraps to 0.
  - Timer holds while scrub_en=0; pending is kept.
  - scrub_pending clears on grant.
  - scrub_addr increments after each scrub CHK and wraps DEPTH-1 → 0.
  - Scrub accesses produce no rsp_valid. An uncorrectable scrub word is counted and not rewritten.
- Arbitration (IDLE only):
  - If req_valid and scrub_pending are both set, the grant alternates: scrub wins if last_grant=USER, else user wins.
  - Otherwise whichever is requesting wins.
  - last_grant updates on every grant.
- Injection:
  - Applied at the clock edge in any state: mem[inj_addr] ^= inj_mask.
  - If a write (user or WB) targets the same address in the same cycle, the mask is XORed onto the newly written word.
  - Injection does not affect a read already in CHK.

Decomposition:
- Package ecc_hamming_74_pkg holds:
  - State enum {IDLE, CHK, WB}.
  - Constants CW_W=7 and WORD_W=8.
  - Grant enum {USER, SCRUB}.
- Sub-modules:
  - Reuse the existing ecc_hamming_74_encoder for user writes and WB re-encode.
  - Add one new sub-module, ecc_hamming_74_decoder: combinational; word[7:0] in; data[3:0], corr, uncorr out.

Test Plan:
- Write addr 3 data 4'hA, then read addr 3 → stored word 8'hD2; rsp_valid at T+2; rdata=4'hA; both error flags 0; counters 0.
- After the above, inject mask 8'h04 at addr 3, then read → rdata=4'hA, rsp_err_corr=1, corr_count=1. WB restores 8'hD2; a second read is clean.
- Inject 8'h80 (extra-parity bit) at addr 3, then read → rdata=4'hA, rsp_err_corr=1, WB restores 8'hD2.
- Inject 8'h05 at addr 3, then read → rdata=4'hB, rsp_err_uncorr=1, uncorr_count=1, no WB (word stays 8'hD7). The read repeats uncorrectable.
- SCRUB_INTERVAL=8, scrub_en=1, inject 8'h01 at addr 0 with no user traffic → within 8 cycles scrub corrects addr 0 to 8'h00, corr_count=1, no rsp_valid; scrub_addr advances to 1.
- Continuous req_valid reads with scrub pending → grants alternate user/scrub. Assert rst mid-CHK → no rsp_valid, state IDLE, counters 0, memory all 8'h00.

Source files
------------

// File: rtl/ecc_hamming_74_pkg.sv
// Shared types and constants for the (7,4) Hamming SECDED memory controller.
//   state_e : controller FSM states
//   grant_e : last winner of the memory-port arbitration
//   CW_W    : Hamming codeword width (7)
//   WORD_W  : stored word width, codeword plus overall parity (8)
//   DATA_W  : user data width (4)
package ecc_hamming_74_pkg;

  localparam int unsigned CW_W   = 7;
  localparam int unsigned WORD_W = 8;
  localparam int unsigned DATA_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    CHK,
    WB
  } state_e;

  typedef enum logic {
    USER,
    SCRUB
  } grant_e;

endpackage

// File: rtl/ecc_hamming_74_decoder.sv
// (7,4) Hamming SECDED decoder, purely combinational.
// Ports:
//   word [7:0]  : stored word {overall_parity, codeword[6:0]}
//   data [3:0]  : decoded data, single-bit errors corrected
//   corr        : single-bit error (codeword or overall-parity bit) corrected
//   uncorr      : double-bit error detected, data returned uncorrected
module ecc_hamming_74_decoder
  import ecc_hamming_74_pkg::*;
(
  input  logic [WORD_W-1:0] word,
  output logic [DATA_W-1:0] data,
  output logic              corr,
  output logic              uncorr
);

  logic [CW_W-1:0] cw;
  logic [CW_W-1:0] flip;
  logic [CW_W-1:0] fixed;
  logic [2:0]      syn;
  logic            par;

  always_comb begin
    cw     = word[CW_W-1:0];
    syn[0] = cw[0] ^ cw[2] ^ cw[4] ^ cw[6];
    syn[1] = cw[1] ^ cw[2] ^ cw[5] ^ cw[6];
    syn[2] = cw[3] ^ cw[4] ^ cw[5] ^ cw[6];
    par    = ^word;
    flip   = '0;
    // Odd overall parity means one flipped bit; a zero syndrome then points at the
    // overall-parity bit itself, which needs no data-side fix.
    if (par && (syn != 3'd0)) begin
      flip = CW_W'(1) << (syn - 3'd1);
    end
    fixed  = cw ^ flip;
    corr   = par;
    uncorr = !par && (syn != 3'd0);
    data   = {fixed[6], fixed[5], fixed[4], fixed[2]};
  end

endmodule

// File: rtl/ecc_hamming_74_encoder.sv
// (7,4) Hamming SECDED encoder.
// Ports:
//   data [3:0] : data to encode
//   word [7:0] : {overall_parity, codeword[6:0]}
// Codeword layout: data bits sit at positions 2,4,5,6; parity bits at 0,1,3.
module ecc_hamming_74_encoder
  import ecc_hamming_74_pkg::*;
(
  input  logic [DATA_W-1:0] data,
  output logic [WORD_W-1:0] word
);

  logic [CW_W-1:0] cw;

  always_comb begin
    cw    = '0;
    cw[2] = data[0];
    cw[4] = data[1];
    cw[5] = data[2];
    cw[6] = data[3];
    cw[0] = data[0] ^ data[1] ^ data[3];
    cw[1] = data[0] ^ data[2] ^ data[3];
    cw[3] = data[1] ^ data[2] ^ data[3];
    word  = {^cw, cw};
  end

endmodule

// File: rtl/ecc_hamming_74_mem_ctrl.sv
// ECC-protected 4-bit memory controller with background scrubber.
// Ports:
//   clk, rst                       : clock, synchronous active-high reset
//   req_valid/req_ready            : user request handshake
//   req_write, req_addr, req_wdata : request type, word address, write data
//   rsp_valid                      : one-cycle read response pulse
//   rsp_rdata, rsp_err_corr/uncorr : read data and error flags
//   scrub_en                       : enables background scrubbing
//   inj_valid, inj_addr, inj_mask  : test-only error injection into stored words
//   corr_count, uncorr_count       : saturating error counters (user + scrub)
// A single memory port is shared between user requests and the scrubber; reads
// take IDLE -> CHK (-> WB when a correctable error must be written back).
module ecc_hamming_74_mem_ctrl
  import ecc_hamming_74_pkg::*;
#(
  parameter int unsigned AW             = 4,
  parameter int unsigned SCRUB_INTERVAL = 256,
  parameter int unsigned CNT_W          = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [AW-1:0]     req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err_corr,
  output logic              rsp_err_uncorr,
  input  logic              scrub_en,
  input  logic              inj_valid,
  input  logic [AW-1:0]     inj_addr,
  input  logic [WORD_W-1:0] inj_mask,
  output logic [CNT_W-1:0]  corr_count,
  output logic [CNT_W-1:0]  uncorr_count
);

  localparam int unsigned DEPTH = 2 ** AW;
  localparam int unsigned TW    = (SCRUB_INTERVAL > 1) ? $clog2(SCRUB_INTERVAL) : 1;

  // State
  state_e            state_q, state_d;
  grant_e            last_grant_q;
  logic [WORD_W-1:0] mem_q [DEPTH];
  logic [WORD_W-1:0] rd_word_q;
  logic [AW-1:0]     addr_q;
  logic              scrub_q;
  logic [DATA_W-1:0] wb_data_q;
  logic              rsp_valid_q;
  logic [DATA_W-1:0] rsp_rdata_q;
  logic              rsp_corr_q;
  logic              rsp_uncorr_q;
  logic [CNT_W-1:0]  corr_cnt_q;
  logic [CNT_W-1:0]  uncorr_cnt_q;
  logic [TW-1:0]     timer_q;
  logic [AW-1:0]     scrub_addr_q;
  logic              scrub_pending_q;

  // Datapath / control
  logic              grant_user;
  logic              grant_scrub;
  logic              rd_en;
  logic [AW-1:0]     rd_addr;
  logic              we;
  logic [AW-1:0]     waddr;
  logic [DATA_W-1:0] enc_data;
  logic [WORD_W-1:0] enc_word;
  logic [DATA_W-1:0] dec_data;
  logic              dec_corr;
  logic              dec_uncorr;
  logic              timer_wrap;

  ecc_hamming_74_encoder u_encoder (
    .data (enc_data),
    .word (enc_word)
  );

  ecc_hamming_74_decoder u_decoder (
    .word   (rd_word_q),
    .data   (dec_data),
    .corr   (dec_corr),
    .uncorr (dec_uncorr)
  );

  // Next-state, arbitration and memory-port control
  always_comb begin
    state_d     = state_q;
    grant_user  = 1'b0;
    grant_scrub = 1'b0;
    req_ready   = 1'b0;
    rd_en       = 1'b0;
    rd_addr     = addr_q;
    we          = 1'b0;
    waddr       = addr_q;
    enc_data    = wb_data_q;

    unique case (state_q)
      IDLE: begin
        // On contention the scrubber wins only if the user had the previous grant.
        if (scrub_pending_q && (!req_valid || (last_grant_q == USER))) begin
          grant_scrub = 1'b1;
        end
        req_ready  = !grant_scrub && !rst;
        grant_user = req_valid && req_ready;
        if (grant_scrub) begin
          rd_en   = 1'b1;
          rd_addr = scrub_addr_q;
          state_d = CHK;
        end else if (grant_user) begin
          if (req_write) begin
            we       = 1'b1;
            waddr    = req_addr;
            enc_data = req_wdata;
          end else begin
            rd_en   = 1'b1;
            rd_addr = req_addr;
            state_d = CHK;
          end
        end
      end
      CHK: begin
        state_d = dec_corr ? WB : IDLE;
      end
      WB: begin
        we      = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign timer_wrap = (timer_q == TW'(SCRUB_INTERVAL - 1));

  // Memory array with synchronous read; injection XORs onto whatever lands in the word.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
      rd_word_q <= '0;
    end else begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        if (we && (waddr == AW'(i))) begin
          mem_q[i] <= enc_word ^ ((inj_valid && (inj_addr == AW'(i))) ? inj_mask : '0);
        end else if (inj_valid && (inj_addr == AW'(i))) begin
          mem_q[i] <= mem_q[i] ^ inj_mask;
        end
      end
      if (rd_en) begin
        rd_word_q <= mem_q[rd_addr];
      end
    end
  end

  // Control state, responses, counters and scrub bookkeeping
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      last_grant_q    <= USER;
      addr_q          <= '0;
      scrub_q         <= 1'b0;
      wb_data_q       <= '0;
      rsp_valid_q     <= 1'b0;
      rsp_rdata_q     <= '0;
      rsp_corr_q      <= 1'b0;
      rsp_uncorr_q    <= 1'b0;
      corr_cnt_q      <= '0;
      uncorr_cnt_q    <= '0;
      timer_q         <= '0;
      scrub_addr_q    <= '0;
      scrub_pending_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rsp_valid_q <= 1'b0;

      if (grant_scrub) begin
        last_grant_q <= SCRUB;
      end else if (grant_user) begin
        last_grant_q <= USER;
      end

      if (rd_en) begin
        addr_q  <= rd_addr;
        scrub_q <= grant_scrub;
      end

      if (state_q == CHK) begin
        wb_data_q <= dec_data;
        if (scrub_q) begin
          scrub_addr_q <= scrub_addr_q + AW'(1);
        end else begin
          rsp_valid_q  <= 1'b1;
          rsp_rdata_q  <= dec_data;
          rsp_corr_q   <= dec_corr;
          rsp_uncorr_q <= dec_uncorr;
        end
        if (dec_corr && (corr_cnt_q != '1)) begin
          corr_cnt_q <= corr_cnt_q + CNT_W'(1);
        end
        if (dec_uncorr && (uncorr_cnt_q != '1)) begin
          uncorr_cnt_q <= uncorr_cnt_q + CNT_W'(1);
        end
      end

      if (scrub_en) begin
        timer_q <= timer_wrap ? '0 : timer_q + TW'(1);
      end

      // A fresh request raised on the grant cycle must not be lost.
      if (scrub_en && timer_wrap) begin
        scrub_pending_q <= 1'b1;
      end else if (grant_scrub) begin
        scrub_pending_q <= 1'b0;
      end
    end
  end

  assign rsp_valid      = rsp_valid_q;
  assign rsp_rdata      = rsp_rdata_q;
  assign rsp_err_corr   = rsp_corr_q;
  assign rsp_err_uncorr = rsp_uncorr_q;
  assign corr_count     = corr_cnt_q;
  assign uncorr_count   = uncorr_cnt_q;

endmodule
